// File: rtl/id_ex_stage_if.sv
// ID/EX bundle: decoded instruction, forwarding sources and flush request in;
// registered ALU controls/operands and the combinational load-use stall out.
interface id_ex_stage_if #(
   parameter int DW = 16,
   parameter int RW = 4
);
   logic          valid_ID;
   logic          R_Type_ID;
   logic          J_Type_ID;
   logic          B_Type_Eq_ID;
   logic          B_Type_Neq_ID;
   logic [3:0]    Func_ID;
   logic [RW-1:0] rs1_ID;
   logic [RW-1:0] rs2_ID;
   logic [RW-1:0] rd_ID;
   logic [DW-1:0] rs1_data_ID;
   logic [DW-1:0] rs2_data_ID;
   logic [DW-1:0] imm_ID;
   logic [DW-1:0] pc_ID;
   logic          use_imm_ID;
   logic          reg_write_ID;
   logic          mem_read_ID;
   logic [DW-1:0] Result_EX;
   logic          Is_Address_Taken;
   logic          mem_reg_write;
   logic [RW-1:0] mem_rd;
   logic [DW-1:0] mem_data;

   logic          R_Type_EX;
   logic          J_Type_EX;
   logic          B_Type_Eq_EX;
   logic          B_Type_Neq_EX;
   logic [3:0]    Func_EX;
   logic [DW-1:0] Op1;
   logic [DW-1:0] Op2;
   logic [RW-1:0] rd_EX;
   logic          reg_write_EX;
   logic          mem_read_EX;
   logic [DW-1:0] pc_EX;
   logic          stall_ID;

   modport master (
      output valid_ID, R_Type_ID, J_Type_ID, B_Type_Eq_ID, B_Type_Neq_ID, Func_ID,
             rs1_ID, rs2_ID, rd_ID, rs1_data_ID, rs2_data_ID, imm_ID, pc_ID,
             use_imm_ID, reg_write_ID, mem_read_ID, Result_EX, Is_Address_Taken,
             mem_reg_write, mem_rd, mem_data,
      input  R_Type_EX, J_Type_EX, B_Type_Eq_EX, B_Type_Neq_EX, Func_EX, Op1, Op2,
             rd_EX, reg_write_EX, mem_read_EX, pc_EX, stall_ID
   );

   modport slave (
      input  valid_ID, R_Type_ID, J_Type_ID, B_Type_Eq_ID, B_Type_Neq_ID, Func_ID,
             rs1_ID, rs2_ID, rd_ID, rs1_data_ID, rs2_data_ID, imm_ID, pc_ID,
             use_imm_ID, reg_write_ID, mem_read_ID, Result_EX, Is_Address_Taken,
             mem_reg_write, mem_rd, mem_data,
      output R_Type_EX, J_Type_EX, B_Type_Eq_EX, B_Type_Neq_EX, Func_EX, Op1, Op2,
             rd_EX, reg_write_EX, mem_read_EX, pc_EX, stall_ID
   );
endinterface

// File: rtl/id_ex_stage.sv
// Decode-to-execute register with EX/MEM forwarding; 1-cycle latency.
// Load-use stalls ID for one cycle (bubble into EX); a taken branch flushes and beats the stall.
module id_ex_stage #(
   parameter int DW = 16,
   parameter int RW = 4
) (
   input  logic         clk,
   input  logic         rst,
   id_ex_stage_if.slave bus
);

   typedef enum logic {RUN, HOLD} state_t;

   typedef struct packed {
      logic          r_type;
      logic          j_type;
      logic          beq;
      logic          bneq;
      logic [3:0]    func;
      logic [DW-1:0] op1;
      logic [DW-1:0] op2;
      logic [RW-1:0] rd;
      logic          reg_write;
      logic          mem_read;
      logic [DW-1:0] pc;
   } ex_t;

   state_t        state_q, state_d;
   ex_t           ex_q, ex_d;
   logic [DW-1:0] fwd1, fwd2;
   logic          reads_rs1, reads_rs2;
   logic          load_use;
   logic          flush;
   logic          stall;

   // EX beats MEM; a load in EX has no result yet, so it is never a source here.
   always_comb begin
      fwd1 = bus.rs1_data_ID;
      if (bus.rs1_ID == '0)
         fwd1 = '0;
      else if (ex_q.reg_write && !ex_q.mem_read && ex_q.rd == bus.rs1_ID)
         fwd1 = bus.Result_EX;
      else if (bus.mem_reg_write && bus.mem_rd == bus.rs1_ID)
         fwd1 = bus.mem_data;
   end

   always_comb begin
      fwd2 = bus.rs2_data_ID;
      if (bus.rs2_ID == '0)
         fwd2 = '0;
      else if (ex_q.reg_write && !ex_q.mem_read && ex_q.rd == bus.rs2_ID)
         fwd2 = bus.Result_EX;
      else if (bus.mem_reg_write && bus.mem_rd == bus.rs2_ID)
         fwd2 = bus.mem_data;
   end

   // Jumps read no registers; immediate forms do not read rs2.
   assign reads_rs1 = !bus.J_Type_ID;
   assign reads_rs2 = !bus.J_Type_ID && !bus.use_imm_ID;
   assign load_use  = bus.valid_ID && ex_q.mem_read && ex_q.reg_write && (ex_q.rd != '0) &&
                      ((reads_rs1 && bus.rs1_ID == ex_q.rd) ||
                       (reads_rs2 && bus.rs2_ID == ex_q.rd));
   assign flush     = bus.Is_Address_Taken;

   always_comb begin
      state_d = RUN;
      ex_d    = '0;
      stall   = load_use && !flush && !rst && (state_q == RUN);
      if (stall) begin
         state_d = HOLD;
      end else if (bus.valid_ID && !flush) begin
         ex_d.r_type    = bus.R_Type_ID;
         ex_d.j_type    = bus.J_Type_ID;
         ex_d.beq       = bus.B_Type_Eq_ID;
         ex_d.bneq      = bus.B_Type_Neq_ID;
         ex_d.func      = bus.Func_ID;
         ex_d.rd        = bus.rd_ID;
         ex_d.reg_write = bus.reg_write_ID;
         ex_d.mem_read  = bus.mem_read_ID;
         ex_d.pc        = bus.pc_ID;
         if (bus.J_Type_ID) begin
            ex_d.op1 = bus.pc_ID;
            ex_d.op2 = bus.imm_ID;
         end else if (bus.R_Type_ID) begin
            ex_d.op1 = fwd1;
            ex_d.op2 = bus.use_imm_ID ? bus.imm_ID : fwd2;
         end else begin
            ex_d.op1 = fwd1;
            ex_d.op2 = fwd2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         ex_q    <= '0;
      end else begin
         state_q <= state_d;
         ex_q    <= ex_d;
      end
   end

   assign bus.R_Type_EX     = ex_q.r_type;
   assign bus.J_Type_EX     = ex_q.j_type;
   assign bus.B_Type_Eq_EX  = ex_q.beq;
   assign bus.B_Type_Neq_EX = ex_q.bneq;
   assign bus.Func_EX       = ex_q.func;
   assign bus.Op1           = ex_q.op1;
   assign bus.Op2           = ex_q.op2;
   assign bus.rd_EX         = ex_q.rd;
   assign bus.reg_write_EX  = ex_q.reg_write;
   assign bus.mem_read_EX   = ex_q.mem_read;
   assign bus.pc_EX         = ex_q.pc;
   assign bus.stall_ID      = stall;

endmodule
